// File: rtl/delayed_write_scheduler.sv
// Register file fed by an age-ordered queue of delayed writes plus a direct write port.
// Optional macro DWS_CANCEL_EN adds a per-address cancel of pending writes.
module delayed_write_scheduler #(
  parameter int N_REGS = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int DLY_W  = 4,
  localparam int AW    = $clog2(N_REGS),
  localparam int PCW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DLY_W-1:0]  req_delay,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
`ifdef DWS_CANCEL_EN
  input  logic              cancel_valid,
  input  logic [AW-1:0]     cancel_addr,
`endif
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [PCW-1:0]    pending_cnt,
  output logic [N_REGS-1:0] commit_mask
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]     r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DLY_W-1:0]  r_cnt  [DEPTH];
  logic [PCW-1:0]    r_pcnt;
  logic [DATA_W-1:0] r_regs [N_REGS];
  logic [N_REGS-1:0] r_cmask;

  logic [DEPTH-1:0]  w_occ;
  logic [DEPTH-1:0]  w_mat;
  logic [DEPTH-1:0]  w_free;
  logic [DEPTH-1:0]  w_commit;
  logic              w_accept;
  logic [PCW-1:0]    w_keep;
  logic [PCW-1:0]    w_n_pcnt;
  logic [AW-1:0]     w_n_addr [DEPTH];
  logic [DATA_W-1:0] w_n_data [DEPTH];
  logic [DLY_W-1:0]  w_n_cnt  [DEPTH];
  logic [N_REGS-1:0] w_cmask;

  assign req_ready   = (r_pcnt < PCW'(DEPTH));
  assign w_accept    = req_valid && req_ready && !flush;
  assign pending_cnt = r_pcnt;
  assign commit_mask = r_cmask;
  assign rd_data     = r_regs[rd_addr];

  // Slot classification: occupied, matured this edge, freed, committing
  always_comb begin
    w_occ    = '0;
    w_mat    = '0;
    w_free   = '0;
    w_commit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ[i] = (PCW'(i) < r_pcnt);
      w_mat[i] = w_occ[i] && (r_cnt[i] == DLY_W'(1));
`ifdef DWS_CANCEL_EN
      // A cancelled slot is dropped even if it matures on this same edge
      w_free[i]   = w_mat[i] || (w_occ[i] && cancel_valid && (r_addr[i] == cancel_addr));
      w_commit[i] = w_mat[i] && !(cancel_valid && (r_addr[i] == cancel_addr));
`else
      w_free[i]   = w_mat[i];
      w_commit[i] = w_mat[i];
`endif
    end
  end

  // Compact surviving slots toward index 0 and append the new request behind them
  always_comb begin
    w_keep  = '0;
    w_cmask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_n_addr[i] = '0;
      w_n_data[i] = '0;
      w_n_cnt[i]  = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occ[i] && !w_free[i]) begin
        w_n_addr[w_keep[IW-1:0]] = r_addr[i];
        w_n_data[w_keep[IW-1:0]] = r_data[i];
        w_n_cnt[w_keep[IW-1:0]]  = r_cnt[i] - DLY_W'(1);
        w_keep = w_keep + PCW'(1);
      end
      if (w_commit[i]) begin
        w_cmask[r_addr[i]] = 1'b1;
      end
    end
    if (w_accept) begin
      w_n_addr[w_keep[IW-1:0]] = req_addr;
      w_n_data[w_keep[IW-1:0]] = req_data;
      w_n_cnt[w_keep[IW-1:0]]  = (req_delay == '0) ? DLY_W'(1) : req_delay;
    end
    w_n_pcnt = w_keep + PCW'(w_accept);
  end

  // Queue occupancy and commit strobe
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_pcnt  <= '0;
      r_cmask <= '0;
    end else begin
      r_pcnt  <= w_n_pcnt;
      r_cmask <= w_cmask;
    end
  end

  // Slot payload carries no reset; occupancy alone decides which entries are live
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      r_addr[i] <= w_n_addr[i];
      r_data[i] <= w_n_data[i];
      r_cnt[i]  <= w_n_cnt[i];
    end
  end

  // Register file: later nonblocking assignments win, so scheduled writes
  // override the direct write and younger slots override older ones
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      if (wr_en) begin
        r_regs[wr_addr] <= wr_data;
      end
      if (!flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_commit[i]) begin
            r_regs[r_addr[i]] <= r_data[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_delayed_write_scheduler.sv
// Directed bench for delayed_write_scheduler with hand-computed expectations per scenario.
module tb_delayed_write_scheduler;

  localparam int N_REGS = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int DLY_W  = 4;
  localparam int AW     = 3;
  localparam int PCW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DLY_W-1:0]  req_delay;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
`ifdef DWS_CANCEL_EN
  logic              cancel_valid;
  logic [AW-1:0]     cancel_addr;
`endif
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [PCW-1:0]    pending_cnt;
  logic [N_REGS-1:0] commit_mask;

  int checks = 0;
  int errors = 0;

  delayed_write_scheduler #(
    .N_REGS(N_REGS), .DATA_W(DATA_W), .DEPTH(DEPTH), .DLY_W(DLY_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_delay(req_delay),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush),
`ifdef DWS_CANCEL_EN
    .cancel_valid(cancel_valid), .cancel_addr(cancel_addr),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data),
    .pending_cnt(pending_cnt), .commit_mask(commit_mask)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [AW-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [DLY_W-1:0] dl);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_delay = dl;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (pending_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_pending got %0d want 0", pending_cnt);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b want 1", req_ready);
    end
    checks++;
    if (commit_mask !== 8'h00) begin
      errors++; $display("FAIL reset_mask got %0h want 0", commit_mask);
    end
    for (int a = 0; a < N_REGS; a++) begin
      rd_addr = AW'(a);
      #1;
      checks++;
      if (rd_data !== 32'd0) begin
        errors++; $display("FAIL reset_reg%0d got %0h want 0", a, rd_data);
      end
    end
  endtask

  task automatic test_single_delay;
    int mask_cycles;
    mask_cycles = 0;
    rd_addr = 3'd0;
    set_req(1'b1, 3'd0, 32'd1, 4'd10);
    tick();
    set_req(1'b0, 3'd0, 32'd0, 4'd0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (rd_data !== ((e >= 10) ? 32'd1 : 32'd0)) begin
        errors++; $display("FAIL single_rd edge %0d got %0h want %0h", e, rd_data, (e >= 10) ? 1 : 0);
      end
      checks++;
      if (commit_mask !== ((e == 10) ? 8'h01 : 8'h00)) begin
        errors++; $display("FAIL single_mask edge %0d got %0h want %0h", e, commit_mask, (e == 10) ? 1 : 0);
      end
      if (commit_mask != 8'h00) mask_cycles++;
    end
    checks++;
    if (mask_cycles != 1) begin
      errors++; $display("FAIL single_mask_cycles got %0d want 1", mask_cycles);
    end
  endtask

  task automatic test_chain;
    logic [DATA_W-1:0] exp_rd;
    logic [PCW-1:0]    exp_p;
    rd_addr = 3'd1;
    set_req(1'b1, 3'd1, 32'd2, 4'd15);
    tick();
    checks++;
    if (pending_cnt !== 3'd1) begin
      errors++; $display("FAIL chain_p_e0 got %0d want 1", pending_cnt);
    end
    set_req(1'b1, 3'd1, 32'd1, 4'd10);
    tick();
    set_req(1'b0, 3'd0, 32'd0, 4'd0);
    checks++;
    if (pending_cnt !== 3'd2) begin
      errors++; $display("FAIL chain_p_e1 got %0d want 2", pending_cnt);
    end
    for (int e = 2; e <= 16; e++) begin
      tick();
      exp_rd = (e >= 15) ? 32'd2 : (e >= 11) ? 32'd1 : 32'd0;
      exp_p  = (e >= 15) ? 3'd0 : (e >= 11) ? 3'd1 : 3'd2;
      checks++;
      if (rd_data !== exp_rd) begin
        errors++; $display("FAIL chain_rd edge %0d got %0h want %0h", e, rd_data, exp_rd);
      end
      checks++;
      if (pending_cnt !== exp_p) begin
        errors++; $display("FAIL chain_p edge %0d got %0d want %0d", e, pending_cnt, exp_p);
      end
    end
  endtask

  task automatic test_conflict;
    rd_addr = 3'd3;
    set_req(1'b1, 3'd3, 32'hA, 4'd3);
    tick();
    set_req(1'b1, 3'd3, 32'hB, 4'd2);
    tick();
    set_req(1'b0, 3'd0, 32'd0, 4'd0);
    tick();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hC;
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_data !== 32'hB) begin
      errors++; $display("FAIL conflict_rd got %0h want b", rd_data);
    end
    checks++;
    if (commit_mask !== 8'h08) begin
      errors++; $display("FAIL conflict_mask got %0h want 08", commit_mask);
    end
    checks++;
    if (pending_cnt !== 3'd0) begin
      errors++; $display("FAIL conflict_p got %0d want 0", pending_cnt);
    end
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h55;
    rd_addr = 3'd4;
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_data !== 32'h55) begin
      errors++; $display("FAIL direct_rd got %0h want 55", rd_data);
    end
    checks++;
    if (commit_mask !== 8'h00) begin
      errors++; $display("FAIL direct_mask got %0h want 00", commit_mask);
    end
  endtask

  task automatic test_full_queue;
    int pexp [8] = '{4, 3, 3, 2, 1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 3'd6, 32'h10 + 32'(i), 4'd5);
      tick();
    end
    rd_addr = 3'd7;
    set_req(1'b1, 3'd7, 32'h77, 4'd5);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_e3 got %0b want 0", req_ready);
    end
    for (int e = 4; e <= 11; e++) begin
      tick();
      if (e == 6) req_valid = 1'b0;
      checks++;
      if (pending_cnt !== PCW'(pexp[e-4])) begin
        errors++; $display("FAIL full_p edge %0d got %0d want %0d", e, pending_cnt, pexp[e-4]);
      end
      checks++;
      if (rd_data !== ((e >= 11) ? 32'h77 : 32'h0)) begin
        errors++; $display("FAIL full_rd7 edge %0d got %0h want %0h", e, rd_data, (e >= 11) ? 32'h77 : 32'h0);
      end
      if (e == 4) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL full_ready_e4 got %0b want 0", req_ready);
        end
      end
      if (e == 5) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL full_ready_e5 got %0b want 1", req_ready);
        end
      end
    end
    rd_addr = 3'd6;
    #1;
    checks++;
    if (rd_data !== 32'h13) begin
      errors++; $display("FAIL full_rd6 got %0h want 13", rd_data);
    end
  endtask

  task automatic test_flush;
    logic [AW-1:0]     addrs [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [DATA_W-1:0] vals  [5] = '{32'h1, 32'h2, 32'h0, 32'h66, 32'h0};
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, AW'(i), 32'hF0 + 32'(i), 4'd8);
      tick();
    end
    set_req(1'b1, 3'd5, 32'h99, 4'd1);
    flush = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h66;
    tick();
    set_req(1'b0, 3'd0, 32'd0, 4'd0);
    flush = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (pending_cnt !== 3'd0) begin
      errors++; $display("FAIL flush_p got %0d want 0", pending_cnt);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (commit_mask !== 8'h00) begin
        errors++; $display("FAIL flush_mask cycle %0d got %0h want 00", c, commit_mask);
      end
    end
    for (int k = 0; k < 5; k++) begin
      rd_addr = addrs[k];
      #1;
      checks++;
      if (rd_data !== vals[k]) begin
        errors++; $display("FAIL flush_reg%0d got %0h want %0h", addrs[k], rd_data, vals[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, AW'(i), 32'hE0 + 32'(i), 4'd8);
      tick();
    end
    set_req(1'b1, 3'd5, 32'h99, 4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 3'd0, 32'd0, 4'd0);
    checks++;
    if (pending_cnt !== 3'd0) begin
      errors++; $display("FAIL rstmid_p got %0d want 0", pending_cnt);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %0b want 1", req_ready);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (commit_mask !== 8'h00) begin
        errors++; $display("FAIL rstmid_mask cycle %0d got %0h want 00", c, commit_mask);
      end
    end
    for (int a = 0; a < N_REGS; a++) begin
      rd_addr = AW'(a);
      #1;
      checks++;
      if (rd_data !== 32'd0) begin
        errors++; $display("FAIL rstmid_reg%0d got %0h want 0", a, rd_data);
      end
    end
  endtask

`ifdef DWS_CANCEL_EN
  task automatic test_cancel;
    set_req(1'b1, 3'd5, 32'h5A, 4'd4);
    tick();
    set_req(1'b1, 3'd2, 32'h2B, 4'd4);
    tick();
    set_req(1'b0, 3'd0, 32'd0, 4'd0);
    cancel_valid = 1'b1; cancel_addr = 3'd2;
    tick();
    cancel_valid = 1'b0;
    checks++;
    if (pending_cnt !== 3'd1) begin
      errors++; $display("FAIL cancel_p got %0d want 1", pending_cnt);
    end
    tick();
    tick();
    rd_addr = 3'd5;
    #1;
    checks++;
    if (commit_mask !== 8'h20) begin
      errors++; $display("FAIL cancel_mask got %0h want 20", commit_mask);
    end
    checks++;
    if (rd_data !== 32'h5A) begin
      errors++; $display("FAIL cancel_rd5 got %0h want 5a", rd_data);
    end
    rd_addr = 3'd2;
    tick();
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL cancel_rd2 got %0h want 0", rd_data);
    end
    checks++;
    if (commit_mask !== 8'h00) begin
      errors++; $display("FAIL cancel_mask_after got %0h want 00", commit_mask);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_req(1'b0, 3'd0, 32'd0, 4'd0);
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    flush = 1'b0;
    rd_addr = '0;
`ifdef DWS_CANCEL_EN
    cancel_valid = 1'b0; cancel_addr = '0;
`endif
    test_reset();
    test_single_delay();
    test_chain();
    test_conflict();
    test_full_queue();
    test_flush();
    test_reset_mid();
`ifdef DWS_CANCEL_EN
    test_cancel();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delayed_write_scheduler.md
# delayed_write_scheduler

Synthesizable scheduler for delayed register writes. It owns a small register file and a queue of pending writes. Each write carries a cycle delay and commits to the register file exactly that many clock edges after acceptance. Writes that mature on the same edge are resolved in acceptance order, youngest last, so the register file behaves like an ordered set of delayed nonblocking assignments that share one set of registers.

## Interface
- `N_REGS`, 8: number of registers in the file; power of two, 2..32.
- `DATA_W`, 32: register and data width.
- `DEPTH`, 4: pending-write slots, 1..16.
- `DLY_W`, 4: delay field width; maximum delay is 2^DLY_W−1.
- `AW`: derived, clog2(N_REGS).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: scheduled-write request.
- `req_ready` out 1: a slot is free; equals `pending_cnt < DEPTH`.
- `req_addr` in AW: target register.
- `req_data` in DATA_W: value to write.
- `req_delay` in DLY_W: commit delay in edges; 0 is treated as 1.
- `wr_en` in 1: direct write; commits on the next edge.
- `wr_addr` in AW / `wr_data` in DATA_W: direct write target and value.
- `flush` in 1: discard all pending slots.
- `rd_addr` in AW: read address.
- `rd_data` out DATA_W: combinational read of the register file.
- `pending_cnt` out clog2(DEPTH+1): number of occupied slots.
- `commit_mask` out N_REGS: bit i is high for one cycle after register i was written by a matured scheduled write.

## Operation
- Slots form an age-ordered queue. Index 0 is the oldest. Each slot holds addr, data and a countdown `cnt`.
- Accept:
  - Condition: `req_valid && req_ready` at an edge.
  - The request is appended at index `pending_cnt − matured_this_edge` with `cnt = max(req_delay, 1)`.
- Each edge, for every occupied slot:
  - `cnt == 1`: commit to `regs[addr]` and free the slot.
  - Otherwise: decrement `cnt`.
- Freed slots are removed and the remaining slots compact toward index 0, preserving relative order.
- Same-edge conflicts:
  - Several matured slots to the same address: the highest-index (youngest) slot wins.
  - A matured scheduled write beats a direct write to the same address.
  - Writes to different addresses all commit.
- `req_ready` does not count slots freed on the current edge. A full queue does not accept on the edge where a slot matures.
- `flush`:
  - All slots are cleared without committing.
  - A request presented with flush is not accepted; `req_ready` is ignored for that edge.
  - A direct write presented with flush still commits.
- Reset:
  - `regs` all 0, slots empty, `pending_cnt` 0, `commit_mask` 0.
  - `req_ready` is 1 from the first cycle after reset.
  - Reset mid-operation discards pending writes with no commits.

## Timing
- A scheduled write accepted at edge E0 with delay d≥1 updates the register at edge E0+d.
  - `rd_data` shows the new value in the cycle after E0+d.
  - `commit_mask` is high during that same cycle.
- A direct write at edge E updates the register at E; it is visible in the following cycle.
- `rd_data` has zero-cycle latency from `rd_addr`.
- `pending_cnt` after an edge equals the previous value, plus 1 for an accepted request, minus the number of slots that matured on that edge.
- Edge rate: at most one accept per edge, and up to DEPTH commits per edge.

## Configuration
- `DWS_CANCEL_EN` defined:
  - Adds input ports `cancel_valid` (1) and `cancel_addr` (AW).
  - On an edge with `cancel_valid`, every occupied slot targeting `cancel_addr` is freed without committing. This includes slots that would mature on that edge.
  - A request accepted on the same edge is never cancelled, even if it targets `cancel_addr`.
- `DWS_CANCEL_EN` undefined: the ports are absent and the queue contains no cancel logic.

## Test plan
- Single delay:
  - After reset, write addr 0 with data 1 and delay 10.
  - `rd_data`@0 reads 0 through the cycle after edge 9 and reads 1 from the cycle after edge 10.
  - `commit_mask` equals 0x01 for exactly one cycle.
- Dependent chain:
  - Schedule addr 1 = 2 with delay 15 at E0, and addr 1 = 1 with delay 10 at E1.
  - Register 1 reads 1 after E11 and 2 after E15.
  - `pending_cnt` steps 1, 2, then 1 after E11, then 0 after E15.
- Same-edge conflict:
  - Accept addr 3 = 0xA with delay 3 at E0 and addr 3 = 0xB with delay 2 at E1; both mature at E3.
  - A direct write of 0xC to addr 3 occurs at E3.
  - Register 3 reads 0xB.
- Full queue:
  - Fill DEPTH=4 slots with delay 5. `req_ready` is 0.
  - A held request is not accepted at the first maturing edge and is accepted on the following edge.
- Flush and reset:
  - With 3 pending writes, assert `flush` together with `req_valid`.
  - Result: `pending_cnt` 0, no commits, and the register file is unchanged.
  - Repeat the scenario using `rst` instead of `flush`: all registers read 0.
- With `DWS_CANCEL_EN`:
  - Pending writes to addr 2 with delay 4 and addr 5 with delay 4; cancel addr 2 at E2.
  - Only register 5 updates at E4, and `commit_mask` equals 0x20.
